// File: rtl/alu_pkg.sv
// Shared constants, state encoding and operand helpers for the sequential divider.
package alu_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = DIV_WIDTH;
  localparam int CNT_WIDTH = $clog2(DIV_ITERS);

  typedef logic [DIV_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FIX    = 2'd2,
    ST_FINISH = 2'd3
  } div_state_e;

  // Absolute value for signed operation; unsigned operands pass straight through.
  function automatic word_t magnitude(input word_t value, input logic is_signed);
    return (is_signed && value[DIV_WIDTH-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, keep or restore.
module div_step
  import alu_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_in,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 dividend_msb,
  output logic [DIV_WIDTH-1:0] rem_out,
  output logic                 quo_bit
);

  logic [DIV_WIDTH:0]   shifted;
  logic [DIV_WIDTH-1:0] diff;

  assign shifted = {rem_in, dividend_msb};
  assign quo_bit = (shifted >= {1'b0, divisor});
  // When the subtract is taken the result is below the divisor, so 32 bits suffice.
  assign diff    = shifted[DIV_WIDTH-1:0] - divisor;
  assign rem_out = quo_bit ? diff : shifted[DIV_WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned 32-bit divider: one restoring step per cycle, fixed latency.
module seq_divider
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [DIV_WIDTH-1:0] a,
  input  logic [DIV_WIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] low,
  output logic [DIV_WIDTH-1:0] high,
  output logic                 div_by_zero
);

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DIV_ITERS - 1);

  div_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q;
  word_t                quo_q;
  word_t                divisor_q;
  word_t                rem_q;
  word_t                a_q;
  logic                 neg_quo_q;
  logic                 neg_rem_q;
  logic                 dbz_q;

  logic                 load_en, step_en, fix_en, finish_en;
  word_t                step_rem;
  logic                 step_bit;

  div_step u_div_step (
    .rem_in       (rem_q),
    .divisor      (divisor_q),
    .dividend_msb (quo_q[DIV_WIDTH-1]),
    .rem_out      (step_rem),
    .quo_bit      (step_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_CALC;
      ST_CALC:   if (count_q == LAST_ITER) state_d = ST_FIX;
      ST_FIX:    state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_en   = 1'b0;
    step_en   = 1'b0;
    fix_en    = 1'b0;
    finish_en = 1'b0;
    busy      = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE:   load_en   = start;
      ST_CALC:   step_en   = 1'b1;
      ST_FIX:    fix_en    = 1'b1;
      ST_FINISH: finish_en = 1'b1;
      default:   ;
    endcase
  end

  // Working registers: quo_q starts as the dividend magnitude and fills with quotient bits.
  // NOTE: the datapath is a handful of flops, not a memory, so all of it takes the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      a_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else if (load_en) begin
      count_q   <= '0;
      quo_q     <= magnitude(a, signed_op);
      divisor_q <= magnitude(b, signed_op);
      rem_q     <= '0;
      a_q       <= a;
      neg_quo_q <= signed_op & (a[DIV_WIDTH-1] ^ b[DIV_WIDTH-1]);
      neg_rem_q <= signed_op & a[DIV_WIDTH-1];
      dbz_q     <= (b == '0);
    end else if (step_en) begin
      count_q   <= count_q + CNT_WIDTH'(1);
      quo_q     <= {quo_q[DIV_WIDTH-2:0], step_bit};
      rem_q     <= step_rem;
    end else if (fix_en) begin
      if (dbz_q) begin
        quo_q <= '1;
        rem_q <= a_q;
      end else begin
        quo_q <= neg_quo_q ? -quo_q : quo_q;
        rem_q <= neg_rem_q ? -rem_q : rem_q;
      end
    end
  end

  // Result registers only change in FINISH, so they hold steady across a whole operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      low         <= '0;
      high        <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= finish_en;
      if (finish_en) begin
        low         <= quo_q;
        high        <= rem_q;
        div_by_zero <= dbz_q;
      end
    end
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 RST_N  input  1  reset, asynchronous, active-low.
REQ-003 START  input  1  request; sampled only in IDLE.
REQ-004 SIGNED_OP  input  1  1 = two's-complement divide, 0 = unsigned; captured with START.
REQ-005 A  input  32  dividend; captured with START.
REQ-006 B  input  32  divisor; captured with START.
REQ-007 BUSY  output  1  high from the capture edge until DONE is asserted.
REQ-008 DONE  output  1  one-cycle pulse; LOW/HIGH valid from this cycle onward.
REQ-009 LOW  output  32  quotient, same LOW/HIGH result pairing as the ALU multiplier.
REQ-010 HIGH  output  32  remainder.
REQ-011 DIV_BY_ZERO  output  1  set with DONE when captured B == 0; held with LOW/HIGH.

Function
REQ-012 The block SHALL use four states: IDLE, CALC, FIX, FINISH.
REQ-013 IDLE with START=1 SHALL capture A, B and SIGNED_OP, take operand magnitudes when signed, clear the partial remainder, zero the iteration counter, and enter CALC.
REQ-014 CALC SHALL perform one restoring step per cycle (shift, trial subtract, keep or restore, shift in the quotient bit) for exactly 32 cycles, then enter FIX.
REQ-015 FIX SHALL negate the quotient when signed and the operand signs differ, and SHALL give the remainder the sign of the dividend; it then enters FINISH.
REQ-016 FINISH SHALL register LOW, HIGH and DIV_BY_ZERO, pulse DONE for one cycle, and return to IDLE.
REQ-017 Latency: DONE SHALL be high in the cycle following the 34th rising edge after the START-sampling edge, fixed for all operands.
REQ-018 BUSY SHALL be high from the START-sampling edge through the FIX cycle, and low in the DONE cycle.
REQ-019 A back-to-back START sampled in the DONE cycle SHALL be accepted.
REQ-020 START while BUSY SHALL be ignored; captured operands SHALL not change mid-operation.
REQ-021 B == 0 SHALL yield LOW = 0xFFFFFFFF, HIGH = captured A, DIV_BY_ZERO = 1, with the normal latency, for both signed and unsigned.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LOW = 0x80000000, HIGH = 0, DIV_BY_ZERO = 0.
REQ-023 LOW, HIGH and DIV_BY_ZERO SHALL hold their values until the next FINISH; they SHALL not toggle during CALC.
REQ-024 The invariant A == LOW*B + HIGH (mod 2^32) SHALL hold whenever B != 0.

Reset
REQ-025 RST_N low SHALL immediately force IDLE, BUSY=0, DONE=0, LOW=0, HIGH=0, DIV_BY_ZERO=0, counter=0, internal operands=0.
REQ-026 Reset during CALC or FIX SHALL abort the operation with no DONE; the first START after release SHALL behave normally.

Structure
REQ-027 Shared package alu_pkg SHALL hold the state encoding, DIV_WIDTH = 32 and the DIV_ITERS constant; no other module-local magic numbers.
REQ-028 One combinational sub-module, div_step, SHALL implement a single restoring iteration (remainder in, divisor, dividend MSB in -> remainder out, quotient bit); seq_divider instantiates it once.
REQ-029 Total RTL SHALL be synthesizable with no latches and no multi-cycle combinational divide.

Verification
REQ-030 Unsigned 7 / 2 -> DONE on the 34th-edge cycle; LOW = 3, HIGH = 1, DIV_BY_ZERO = 0.
REQ-031 Signed 0xFFFFFFF9 (-7) / 2 -> LOW = 0xFFFFFFFD, HIGH = 0xFFFFFFFF; signed 0xFFFFFFE2 (-30) / 0xFFFFFFFA (-6) -> LOW = 5, HIGH = 0.
REQ-032 Unsigned 0xFFFFFFFB / 6 -> LOW = 0x2AAAAAA9, HIGH = 5; the same operands signed -> LOW = 0, HIGH = 0xFFFFFFFB.
REQ-033 A = 10, B = 0 (signed and unsigned) -> LOW = 0xFFFFFFFF, HIGH = 10, DIV_BY_ZERO = 1; signed 0x80000000 / 0xFFFFFFFF -> LOW = 0x80000000, HIGH = 0.
REQ-034 START pulsed again at cycle 5 with new operands -> ignored, first result unchanged; START held high through DONE -> second operation accepted and completes 34 edges later.
REQ-035 RST_N asserted at cycle 15 of an operation -> outputs 0 at once, no DONE; a fresh 100 / 7 after release -> LOW = 14, HIGH = 2.
